// File: rtl/niosintr_cpu_div_pkg.sv
// niosintr_cpu_div_pkg
//   Shared definitions for the iterative divider cell:
//     div_state_e        - divider FSM states (IDLE, CALC, FIX, DONE)
//     DIV_WIDTH_DEFAULT  - default operand/result width
//     DIV_ZERO_QUOT_BIT  - fill bit of the quotient returned for a zero divisor
//                          (the quotient is this bit replicated WIDTH times)
package niosintr_cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/niosintr_cpu_div_step.sv
// niosintr_cpu_div_step
//   One radix-2 restoring division iteration, purely combinational.
//   Ports:
//     rem_in   [WIDTH-1:0]  partial remainder entering the iteration (< divisor)
//     bit_in                next dividend bit shifted into the remainder
//     divisor  [WIDTH-1:0]  divisor magnitude
//     rem_out  [WIDTH-1:0]  partial remainder after the iteration
//     q_bit                 quotient bit produced by the iteration
module niosintr_cpu_div_step
    import niosintr_cpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    always_comb begin
        shifted = {rem_in, bit_in};
        // The difference is only kept when shifted >= divisor, and then it is
        // below the divisor, so the low WIDTH bits of a modular subtract suffice.
        trial   = shifted[WIDTH-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? trial : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/niosintr_cpu_div_cell.sv
// niosintr_cpu_div_cell
//   Multi-cycle signed/unsigned integer divider: WIDTH restoring iterations
//   on operand magnitudes, then one cycle of sign correction.
//   Ports:
//     clk            clock, all state changes on the rising edge
//     reset_n        synchronous active-low reset
//     E_src1         dividend, sampled with start
//     E_src2         divisor, sampled with start
//     E_div_start    request a division (accepted in IDLE or DONE only)
//     E_div_signed   1 = two's-complement operands, sampled with start
//     E_div_abort    flush: cancels anything in flight, wins over start
//     M_div_busy     high in CALC and FIX
//     M_div_done     one-cycle pulse, results valid in that cycle
//     M_div_quot     quotient, updated on entry to DONE only
//     M_div_rem      remainder, updated on entry to DONE only
//     M_div_by_zero  last result came from a zero divisor
//   Build option:
//     NIOSINTR_DIV_ZERO_FAST_EN  when defined, a zero divisor goes straight
//                                to DONE on the accepting edge.
module niosintr_cpu_div_cell
    import niosintr_cpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             E_div_abort,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_by_zero
);

    // Counter holds 0..WIDTH so it never wraps during one operation.
    localparam int unsigned    CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

`ifdef NIOSINTR_DIV_ZERO_FAST_EN
    localparam logic FAST_ZERO = 1'b1;
`else
    localparam logic FAST_ZERO = 1'b0;
`endif

    div_state_e       state, state_nxt;

    logic [WIDTH-1:0] part_rem;     // running partial remainder
    logic [WIDTH-1:0] dvd_q;        // dividend bits shift out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs;          // divisor magnitude
    logic             neg_q;        // quotient must be negated
    logic             neg_r;        // remainder must be negated (dividend negative)
    logic             zero_div;     // divisor was zero
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic             src2_zero;
    logic             can_start;
    logic             accept;
    logic             fast_hit;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    niosintr_cpu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (part_rem),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        src1_mag  = (E_div_signed && E_src1[WIDTH-1]) ? -E_src1 : E_src1;
        src2_mag  = (E_div_signed && E_src2[WIDTH-1]) ? -E_src2 : E_src2;
        src2_zero = (E_src2 == '0);
        can_start = (state == IDLE) || (state == DONE);
        accept    = can_start && E_div_start && !E_div_abort;
        fast_hit  = FAST_ZERO && src2_zero;
    end

    // Sign correction. For a zero divisor the remainder magnitude equals
    // |src1|, so re-applying the dividend sign reproduces src1 exactly.
    always_comb begin
        quot_fix = neg_q ? -dvd_q : dvd_q;
        rem_fix  = neg_r ? -part_rem : part_rem;
        if (zero_div) begin
            quot_fix = {WIDTH{DIV_ZERO_QUOT_BIT}};
        end
    end

    always_comb begin
        state_nxt = state;
        if (E_div_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (E_div_start) begin
                        state_nxt = fast_hit ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (count == LAST_ITER) begin
                        state_nxt = FIX;
                    end
                end
                FIX: begin
                    state_nxt = DONE;
                end
                DONE: begin
                    if (E_div_start) begin
                        state_nxt = fast_hit ? DONE : CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            part_rem      <= '0;
            dvd_q         <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            zero_div      <= 1'b0;
            count         <= '0;
            M_div_quot    <= '0;
            M_div_rem     <= '0;
            M_div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                part_rem <= '0;
                dvd_q    <= src1_mag;
                dvs      <= src2_mag;
                neg_q    <= E_div_signed && (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
                neg_r    <= E_div_signed && E_src1[WIDTH-1];
                zero_div <= src2_zero;
                count    <= '0;
                if (fast_hit) begin
                    M_div_quot    <= {WIDTH{DIV_ZERO_QUOT_BIT}};
                    M_div_rem     <= E_src1;
                    M_div_by_zero <= 1'b1;
                end
            end else if (!E_div_abort) begin
                if (state == CALC) begin
                    part_rem <= step_rem;
                    dvd_q    <= {dvd_q[WIDTH-2:0], step_q};
                    count    <= count + CW'(1);
                end else if (state == FIX) begin
                    M_div_quot    <= quot_fix;
                    M_div_rem     <= rem_fix;
                    M_div_by_zero <= zero_div;
                end
            end
        end
    end

    assign M_div_busy = (state == CALC) || (state == FIX);
    assign M_div_done = (state == DONE);

endmodule

// File: tb/tb_niosintr_cpu_div_cell.sv
module tb_niosintr_cpu_div_cell;

    localparam int unsigned WIDTH = 32;
    localparam int          LIMIT = WIDTH + 10;

`ifdef NIOSINTR_DIV_ZERO_FAST_EN
    localparam logic FAST = 1'b1;
`else
    localparam logic FAST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] src1, src2;
    logic             start, sgn, abort;
    logic             busy, done, bz;
    logic [WIDTH-1:0] quot, rem;

    int n_cmp = 0;
    int n_err = 0;

    // last result the DUT should be presenting
    logic [WIDTH-1:0] mdl_q, mdl_r;
    logic             mdl_bz;

    always #5 clk = ~clk;

    niosintr_cpu_div_cell #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .E_src1        (src1),
        .E_src2        (src2),
        .E_div_start   (start),
        .E_div_signed  (sgn),
        .E_div_abort   (abort),
        .M_div_busy    (busy),
        .M_div_done    (done),
        .M_div_quot    (quot),
        .M_div_rem     (rem),
        .M_div_by_zero (bz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: division rules stated directly.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // in_done: called while sitting in a DONE cycle (start drives immediately)
    // follow : return in the done cycle so the caller can chain a start
    // inject : cycle at which a second start with junk operands is driven (0 = none)
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int inject, input logic in_done,
                           input logic follow);
        logic [31:0] eq, er;
        logic        ez;
        int          exp_lat, lat, busy_bad, hold_bad;
        model(a, b, s, eq, er, ez);
        exp_lat  = (b == 32'd0 && FAST) ? 1 : WIDTH + 2;
        lat      = 0;
        busy_bad = 0;
        hold_bad = 0;
        if (!in_done) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1; src1 = a; src2 = b; sgn = s;
        for (int k = 1; k <= LIMIT && lat == 0; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = k;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (quot !== mdl_q || rem !== mdl_r || bz !== mdl_bz) hold_bad++;
            end
            if (k == inject && inject > 0) begin
                start = 1'b1;
                src1  = $urandom;
                src2  = $urandom;
                sgn   = ~s;
            end
        end
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"},  rem, er);
        check({tag, "_bz"},   32'(bz), 32'(ez));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        mdl_q  = eq;
        mdl_r  = er;
        mdl_bz = ez;
        if (!follow) begin
            @(posedge clk);
            #1;
            check({tag, "_pulse"}, 32'(done), 32'd0);
        end
    endtask

    task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int abort_at);
        int seen_done;
        seen_done = 0;
        @(posedge clk);
        #1;
        start = 1'b1; src1 = a; src2 = b; sgn = 1'b0;
        for (int k = 1; k <= abort_at + WIDTH + 4; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) seen_done++;
            if (k == abort_at) begin
                check("abort_busy_before", 32'(busy), 32'd1);
                abort = 1'b1;
            end
            if (k == abort_at + 1) begin
                abort = 1'b0;
                check("abort_busy_after", 32'(busy), 32'd0);
            end
        end
        check("abort_nodone", 32'(seen_done), 32'd0);
        check("abort_quot_hold", quot, mdl_q);
        check("abort_rem_hold", rem, mdl_r);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        logic        rs;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; sgn = 1'b0;
        src1 = '0; src2 = '0;
        mdl_q = '0; mdl_r = '0; mdl_bz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem",  rem,  32'd0);
        check("rst_bz",   32'(bz), 32'd0);
        reset_n = 1'b1;

        run_div("u100_7",  32'd100,         32'd7,           1'b0, 0, 1'b0, 1'b0);
        run_div("s_m7_2",  32'hFFFF_FFF9,   32'd2,           1'b1, 0, 1'b0, 1'b0);
        run_div("s_7_m2",  32'd7,           32'hFFFF_FFFE,   1'b1, 0, 1'b0, 1'b0);
        run_div("zero5",   32'd5,           32'd0,           1'b0, 0, 1'b0, 1'b0);
        run_div("zero_s",  32'hFFFF_FFFB,   32'd0,           1'b1, 0, 1'b0, 1'b0);
        run_div("ovf",     32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 0, 1'b0, 1'b0);
        run_div("u_big",   32'hFFFF_FFFF,   32'h0001_0000,   1'b0, 0, 1'b0, 1'b0);

        run_abort(32'd20, 32'd3, 10);
        run_div("after_abort", 32'd9, 32'd4, 1'b0, 0, 1'b0, 1'b0);

        run_div("ignored", 32'd50, 32'd5, 1'b0, 5, 1'b0, 1'b0);

        run_div("b2b_a", 32'd1000, 32'd33, 1'b0, 0, 1'b0, 1'b1);
        run_div("b2b_b", 32'hFFFF_FF00, 32'd7, 1'b1, 0, 1'b1, 1'b0);

        // abort and start together: start dropped
        @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1; src1 = 32'd44; src2 = 32'd4; sgn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_start_nodone", 32'(seen), 32'd0);
        check("abort_start_quot", quot, mdl_q);

        // reset mid-operation, asserted together with a fresh start
        @(posedge clk);
        #1;
        start = 1'b1; src1 = 32'd1000; src2 = 32'd3; sgn = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset_n = 1'b0; start = 1'b1; src1 = 32'd77; src2 = 32'd7;
        @(posedge clk);
        #1;
        reset_n = 1'b1; start = 1'b0;
        mdl_q = '0; mdl_r = '0; mdl_bz = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_quot", quot, 32'd0);
        check("midrst_rem",  rem,  32'd0);
        seen = 0;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst_nodone", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 16));
                3:       begin rb = $urandom; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            run_div("rnd", ra, rb, rs, 0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
